// File: rtl/alu_bank_responder.sv
// Four independent ALU bank engines: ADD/SUB/SHL with response LATENCY edges after accept, no backpressure
// (busy banks ignore input). Define ALU_STATS_EN to add saturating per-bank op_count of emitted responses.
module alu_bank_responder #(
    parameter int LATENCY = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [3:0][65:0]  input_packet,
    output logic [3:0][33:0]  output_packet
`ifdef ALU_STATS_EN
    ,
    output logic [3:0][15:0]  op_count
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [1:0] CMD_NOP = 2'd0;
    localparam logic [1:0] CMD_ADD = 2'd1;
    localparam logic [1:0] CMD_SUB = 2'd2;
    localparam logic [1:0] CMD_SHL = 2'd3;

    localparam logic [1:0] RSP_NONE    = 2'd0;
    localparam logic [1:0] RSP_SUCCESS = 2'd1;
    localparam logic [1:0] RSP_OVF     = 2'd2;

    localparam logic [2:0] CNT_LAST = 3'(LATENCY - 1);

    for (genvar b = 0; b < 4; b++) begin : g_bank
        logic [1:0]  state_q, state_d;
        logic [31:0] op1_q, op1_d;
        logic [31:0] op2_q, op2_d;
        logic [1:0]  cmd_q, cmd_d;
        logic [2:0]  cnt_q, cnt_d;
        logic [31:0] data_q, data_d;
        logic [1:0]  resp_q, resp_d;

        logic [1:0]  cmd_in;
        logic [32:0] sum_w;
        logic [32:0] diff_w;
        logic [4:0]  sh_w;
        logic [31:0] res_w;
        logic [1:0]  rc_w;
        logic        emit_w;

        assign cmd_in = input_packet[b][1:0];
        assign sum_w  = {1'b0, op1_q} + {1'b0, op2_q};
        assign diff_w = {1'b0, op1_q} - {1'b0, op2_q};
        assign sh_w   = op2_q[4:0];
        assign emit_w = (state_q == ST_BUSY) && (cnt_q == CNT_LAST);

        // Results come only from the latched operands, so input churn during BUSY is harmless.
        always_comb begin
            res_w = 32'h0;
            rc_w  = RSP_SUCCESS;
            case (cmd_q)
                CMD_ADD: begin
                    res_w = sum_w[31:0];
                    rc_w  = sum_w[32] ? RSP_OVF : RSP_SUCCESS;
                end
                CMD_SUB: begin
                    res_w = diff_w[31:0];
                    rc_w  = diff_w[32] ? RSP_OVF : RSP_SUCCESS;
                end
                CMD_SHL: begin
                    res_w = op1_q << sh_w;
                    rc_w  = (|(op1_q & ~(32'hFFFF_FFFF >> sh_w))) ? RSP_OVF : RSP_SUCCESS;
                end
                default: begin
                    res_w = 32'h0;
                    rc_w  = RSP_SUCCESS;
                end
            endcase
        end

        always_comb begin
            state_d = state_q;
            op1_d   = op1_q;
            op2_d   = op2_q;
            cmd_d   = cmd_q;
            cnt_d   = cnt_q;
            data_d  = data_q;
            resp_d  = resp_q;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_in != CMD_NOP) begin
                        op1_d   = input_packet[b][65:34];
                        op2_d   = input_packet[b][33:2];
                        cmd_d   = cmd_in;
                        cnt_d   = 3'd0;
                        state_d = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    cnt_d = cnt_q + 3'd1;
                    if (emit_w) begin
                        data_d  = res_w;
                        resp_d  = rc_w;
                        state_d = ST_RESP;
                    end
                end
                ST_RESP: begin
                    resp_d  = RSP_NONE;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        always_ff @(posedge clock) begin
            if (!reset) begin
                state_q <= ST_IDLE;
                op1_q   <= 32'h0;
                op2_q   <= 32'h0;
                cmd_q   <= CMD_NOP;
                cnt_q   <= 3'd0;
                data_q  <= 32'h0;
                resp_q  <= RSP_NONE;
            end else begin
                state_q <= state_d;
                op1_q   <= op1_d;
                op2_q   <= op2_d;
                cmd_q   <= cmd_d;
                cnt_q   <= cnt_d;
                data_q  <= data_d;
                resp_q  <= resp_d;
            end
        end

        assign output_packet[b] = {data_q, resp_q};

`ifdef ALU_STATS_EN
        logic [15:0] ops_q, ops_d;

        always_comb begin
            ops_d = ops_q;
            if (emit_w && (ops_q != 16'hFFFF)) begin
                ops_d = ops_q + 16'd1;
            end
        end

        always_ff @(posedge clock) begin
            if (!reset) begin
                ops_q <= 16'h0;
            end else begin
                ops_q <= ops_d;
            end
        end

        assign op_count[b] = ops_q;
`endif
    end

endmodule

// File: tb/tb_alu_bank_responder.sv
// Drives LATENCY=3,4,5 instances with one shared stimulus and checks each against a deadline-based bank model.
module tb_alu_bank_responder;

    logic              clock = 1'b0;
    logic              reset;
    logic [3:0][65:0]  inp;
    logic [3:0][33:0]  outp [3];
`ifdef ALU_STATS_EN
    logic [3:0][15:0]  opc [3];
`endif

    always #5 clock = ~clock;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        alu_bank_responder #(.LATENCY(3 + g)) u_dut (
            .clock         (clock),
            .reset         (reset),
            .input_packet  (inp),
            .output_packet (outp[g])
`ifdef ALU_STATS_EN
            ,
            .op_count      (opc[g])
`endif
        );
    end

    int          n_tests = 0;
    int          n_fail  = 0;
    int          edge_n  = 0;

    bit          m_pend  [3][4];
    int          m_redge [3][4];
    int          m_free  [3][4];
    int          m_ops   [3][4];
    logic [31:0] m_res   [3][4];
    logic [1:0]  m_rc    [3][4];
    logic [31:0] e_data  [3][4];
    logic [1:0]  e_resp  [3][4];

    function automatic void ref_op(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output logic [1:0] rc);
        longint unsigned wide;
        case (c)
            2'd1: begin
                wide = longint'(a) + longint'(b);
                r    = wide[31:0];
                rc   = (wide > 64'hFFFF_FFFF) ? 2'd2 : 2'd1;
            end
            2'd2: begin
                r  = a - b;
                rc = (a < b) ? 2'd2 : 2'd1;
            end
            default: begin
                wide = longint'(a) * (64'd1 << b[4:0]);
                r    = wide[31:0];
                rc   = (wide[63:32] != 32'h0) ? 2'd2 : 2'd1;
            end
        endcase
    endfunction

    task automatic model_edge();
        logic [1:0] c;
        for (int i = 0; i < 3; i++) begin
            for (int b = 0; b < 4; b++) begin
                c = inp[b][1:0];
                if (!reset) begin
                    m_pend[i][b] = 1'b0;
                    m_free[i][b] = 0;
                    m_ops[i][b]  = 0;
                    e_data[i][b] = 32'h0;
                    e_resp[i][b] = 2'd0;
                end else begin
                    e_resp[i][b] = 2'd0;
                    if (m_pend[i][b] && edge_n == m_redge[i][b]) begin
                        e_data[i][b] = m_res[i][b];
                        e_resp[i][b] = m_rc[i][b];
                        m_pend[i][b] = 1'b0;
                        if (m_ops[i][b] < 65535) m_ops[i][b]++;
                    end
                    if (!m_pend[i][b] && edge_n >= m_free[i][b] && c != 2'd0) begin
                        ref_op(c, inp[b][65:34], inp[b][33:2], m_res[i][b], m_rc[i][b]);
                        m_pend[i][b]  = 1'b1;
                        m_redge[i][b] = edge_n + 3 + i;
                        m_free[i][b]  = edge_n + 3 + i + 2;
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 3; i++) begin
            for (int b = 0; b < 4; b++) begin
                n_tests++;
                if (outp[i][b] !== {e_data[i][b], e_resp[i][b]}) begin
                    n_fail++;
                    if (n_fail < 40)
                        $display("FAIL model L=%0d bank%0d edge%0d: got %h required %h", 3 + i, b, edge_n,
                                 outp[i][b], {e_data[i][b], e_resp[i][b]});
                end
`ifdef ALU_STATS_EN
                n_tests++;
                if (opc[i][b] !== 16'(m_ops[i][b])) begin
                    n_fail++;
                    if (n_fail < 40)
                        $display("FAIL op_count L=%0d bank%0d edge%0d: got %0d required %0d", 3 + i, b, edge_n,
                                 opc[i][b], m_ops[i][b]);
                end
`endif
            end
        end
    endtask

    task automatic step();
        @(posedge clock);
        edge_n++;
        #1;
        model_edge();
        compare_all();
    endtask

    task automatic lit(input string nm, input logic [33:0] got, input logic [33:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, got, want);
        end
    endtask

    // One directed op on a bank; literal checks target the LATENCY=4 instance.
    task automatic dir_op(input int b, input logic [1:0] c, input logic [31:0] d1, input logic [31:0] d2,
                          input bit chg_d1, input logic [33:0] want, input string nm);
        inp[b] = {d1, d2, c};
        step();
        if (chg_d1) inp[b][65:34] = 32'h0;
        else        inp[b] = '0;
        step();
        inp[b] = '0;
        step();
        step();
        lit({nm, "_early"}, outp[1][b], {outp[1][b][33:2], 2'd0});
        step();
        lit(nm, outp[1][b], want);
        step();
        lit({nm, "_hold"}, outp[1][b], {want[33:2], 2'd0});
        step();
        step();
    endtask

    function automatic logic [31:0] pick_data();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'(($urandom_range(0, 63)));
            default: return $urandom;
        endcase
    endfunction

    int hold_cnt [4];

    initial begin
        reset = 1'b0;
        inp   = '0;
        step();
        for (int b = 0; b < 4; b++) lit($sformatf("reset_b%0d", b), outp[1][b], 34'h0);
        reset = 1'b1;
        step();

        dir_op(0, 2'd1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, {32'h0000_0000, 2'd2}, "add_ovf");
        dir_op(1, 2'd2, 32'h0000_0010, 32'h0000_0003, 1'b1, {32'h0000_000D, 2'd1}, "sub_busy_chg");
        dir_op(2, 2'd3, 32'h8000_0001, 32'h0000_0021, 1'b0, {32'h0000_0002, 2'd2}, "shl_ovf");
        dir_op(1, 2'd2, 32'h0000_0003, 32'h0000_0005, 1'b0, {32'hFFFF_FFFE, 2'd2}, "sub_borrow");
        dir_op(3, 2'd3, 32'h0000_0001, 32'h0000_001F, 1'b0, {32'h8000_0000, 2'd1}, "shl_31");

        for (int b = 0; b < 4; b++) inp[b] = {32'h1, 32'h1, 2'd1};
        step();
        inp = '0;
        repeat (4) step();
        for (int b = 0; b < 4; b++) lit($sformatf("all4_b%0d", b), outp[1][b], {32'h2, 2'd1});
        repeat (3) step();

        inp[3] = {32'h5, 32'h6, 2'd1};
        step();
        inp[3] = '0;
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        repeat (6) begin
            step();
            lit("abort_b3", outp[1][3], 34'h0);
        end
`ifdef ALU_STATS_EN
        lit("abort_cnt", {18'h0, opc[1][3]}, 34'd0);
`endif
        dir_op(3, 2'd1, 32'h7, 32'h8, 1'b0, {32'hF, 2'd1}, "add_b3a");
        dir_op(3, 2'd2, 32'h9, 32'h9, 1'b0, {32'h0, 2'd1}, "sub_b3b");
        dir_op(3, 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, {32'hFFFF_FFFE, 2'd2}, "add_b3c");
`ifdef ALU_STATS_EN
        lit("three_cnt", {18'h0, opc[1][3]}, 34'd3);
`endif

        // Command presented on the first edge after reset release is taken.
        reset = 1'b0;
        step();
        reset = 1'b1;
        dir_op(0, 2'd1, 32'h10, 32'h20, 1'b0, {32'h30, 2'd1}, "post_reset");

        for (int b = 0; b < 4; b++) hold_cnt[b] = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int b = 0; b < 4; b++) begin
                if (hold_cnt[b] == 0) begin
                    hold_cnt[b] = $urandom_range(1, 8);
                    inp[b] = {pick_data(), pick_data(),
                              ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(1, 3))};
                end else begin
                    hold_cnt[b]--;
                    if ($urandom_range(0, 3) == 0) inp[b][65:2] = {pick_data(), pick_data()};
                end
            end
            reset = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
